// File: rtl/axi4lite_initiator_osd.sv
// AXI4-Lite initiator for the OSD register slave: one outstanding single-beat read or write per
// command, with a saturating watchdog that parks the block in HUNG until reset.
module axi4lite_initiator_osd #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        hung,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_HUNG
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic [31:0]       awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       araddr_q, araddr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;

    logic cmd_fire, aw_left, w_left, b_fire, r_fire, busy, timeout;

    assign cmd_fire = cmd_valid && (state_q == S_IDLE);
    assign aw_left  = awvalid_q && !awready;
    assign w_left   = wvalid_q && !wready;
    assign b_fire   = (state_q == S_WR_RESP) && bvalid;
    assign r_fire   = (state_q == S_RD_RESP) && rvalid;
    assign busy     = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                      (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
    // Last counted cycle; a B/R handshake landing in it still completes normally.
    assign timeout  = (TIMEOUT_CYCLES != 0) && busy && (cnt_q == CNT_LAST);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            araddr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cmd_valid) state_d = cmd_wr ? S_WR_REQ : S_RD_REQ;
            S_WR_REQ:  if (timeout) state_d = S_HUNG;
                       else if (!aw_left && !w_left) state_d = S_WR_RESP;
            S_WR_RESP: if (bvalid) state_d = S_IDLE;
                       else if (timeout) state_d = S_HUNG;
            S_RD_REQ:  if (timeout) state_d = S_HUNG;
                       else if (!(arvalid_q && !arready)) state_d = S_RD_RESP;
            S_RD_RESP: if (rvalid) state_d = S_IDLE;
                       else if (timeout) state_d = S_HUNG;
            S_HUNG:    state_d = S_HUNG;
            default:   state_d = S_IDLE;
        endcase
    end

    // Request valids fall only after their own handshake, including while HUNG.
    always_comb begin
        awvalid_d   = aw_left;
        wvalid_d    = w_left;
        arvalid_d   = arvalid_q && !arready;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        araddr_d    = araddr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        if (cmd_fire) begin
            cnt_d = '0;
            if (cmd_wr) begin
                awaddr_d  = cmd_addr;
                wdata_d   = cmd_wdata;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
            end else begin
                araddr_d  = cmd_addr;
                arvalid_d = 1'b1;
            end
        end else if (busy && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (b_fire) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_resp_d  = bresp;
        end
        if (r_fire) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rdata;
            rsp_resp_d  = rresp;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign bready    = (state_q == S_WR_RESP);
    assign rready    = (state_q == S_RD_RESP);
    assign hung      = (state_q == S_HUNG);
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign arvalid   = arvalid_q;
    assign awaddr    = awaddr_q;
    assign wdata     = wdata_q;
    assign wstrb     = 4'hF;
    assign araddr    = araddr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule
